// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/WB control unit owning pc, IR, Z and the start/done handshake
module core_sequencer #(
  parameter int PC_W  = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic             busy,
  output logic [PC_W-1:0]  pc,
  input  logic [8:0]       instr,
  input  logic             alu_zero,
  output logic [2:0]       rd_sel,
  output logic [2:0]       rs_sel,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [7:0]       imm,
  output logic             mem_re,
  output logic             mem_we,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, DONE} state_t;
  state_t state, state_nx;
  logic [8:0] ir;
  logic [2:0] op;
  logic z, is_alu, is_ldi, is_ldr, is_str, is_brz, is_jmp, is_halt, launch, retire;
  assign op      = ir[8:6];
  assign is_alu  = op < 3'd3;
  assign is_ldi  = op == 3'd3;
  assign is_ldr  = op == 3'd4;
  assign is_str  = op == 3'd5;
  assign is_brz  = op == 3'd6;
  assign is_jmp  = op == 3'd7 && ir[5:0] != 6'd0;
  assign is_halt = op == 3'd7 && ir[5:0] == 6'd0;
  assign launch  = start && (state == IDLE || state == DONE);
  // LDR retires in WB; every other instruction, HALT included, retires in EXEC
  assign retire  = (state == EXEC && !is_ldr) || state == WB;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? FETCH : state;
      FETCH:      state_nx = DECODE;
      DECODE:     state_nx = EXEC;
      EXEC:       state_nx = is_ldr ? WB : is_halt ? DONE : FETCH;
      WB:         state_nx = FETCH;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      z       <= 1'b0;
      retired <= '0;
    end else begin
      if (launch) begin
        pc      <= '0;
        z       <= 1'b0;
        retired <= '0;
      end
      if (state == FETCH) ir <= instr;
      if (state == EXEC && is_alu) z <= alu_zero;
      if (state == EXEC && (is_jmp || (is_brz && z))) pc <= PC_W'(ir[5:0]);
      else if (retire && !is_halt) pc <= pc + 1'b1;
      if (retire && retired != '1) retired <= retired + 1'b1;
    end
  // strobes are masked by reset so an aborted instruction never touches the datapath
  always_comb begin
    done   = state == DONE;
    busy   = state == FETCH || state == DECODE || state == EXEC || state == WB;
    rd_sel = ir[5:3];
    rs_sel = ir[2:0];
    alu_op = is_alu ? ir[7:6] : 2'b00;
    wb_sel = is_ldr ? 2'b10 : is_ldi ? 2'b01 : 2'b00;
    imm    = {5'b0, ir[2:0]};
    reg_we = !reset && ((state == EXEC && (is_alu || is_ldi)) || state == WB);
    mem_re = !reset && state == EXEC && is_ldr;
    mem_we = !reset && state == EXEC && is_str;
  end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: instruction-level reference model checked against core_sequencer every cycle
module tb_core_sequencer;
  localparam int CW = 10;
  localparam logic [8:0] HALT = 9'b111000000;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, load = 1'b1;
  logic done, busy, alu_zero, reg_we, mem_re, mem_we;
  logic [6:0] pc;
  logic [8:0] instr;
  logic [2:0] rd_sel, rs_sel;
  logic [1:0] alu_op, wb_sel;
  logic [7:0] imm, rdata, alu_y;
  logic [CW-1:0] retired;
  logic [8:0] rom [128];
  logic [7:0] init_r [8], r [8], exp_r [8];
  logic [7:0] init_m [256], mem [256], exp_m [256];
  int checks = 0, errors = 0;
  int done_k, re_k, we_k, re_n, mw_n;
  bit halted;
  typedef struct packed {
    logic [6:0] pc;
    logic busy, done, we, re, mw, sel;
    logic [1:0] wb;
    logic [8:0] ir;
    logic [CW-1:0] ret;
  } rec_t;
  rec_t q [$];

  always #5 clk = ~clk;
  assign instr = rom[pc];
  assign alu_y = alu_op == 2'b00 ? r[rd_sel] + r[rs_sel] : alu_op == 2'b01 ? r[rd_sel] - r[rs_sel] : r[rd_sel] & r[rs_sel];
  assign alu_zero = alu_y == 8'h00;

  core_sequencer #(.PC_W(7), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy), .pc(pc),
    .instr(instr), .alu_zero(alu_zero), .rd_sel(rd_sel), .rs_sel(rs_sel), .alu_op(alu_op),
    .reg_we(reg_we), .wb_sel(wb_sel), .imm(imm), .mem_re(mem_re), .mem_we(mem_we), .retired(retired)
  );

  // register file, data memory and read-data register surrounding the sequencer
  always @(posedge clk)
    if (load) begin
      for (int i = 0; i < 8; i++) r[i] <= init_r[i];
      for (int i = 0; i < 256; i++) mem[i] <= init_m[i];
      rdata <= 8'h00;
    end else begin
      if (mem_re) rdata <= mem[r[rs_sel]];
      if (mem_we) mem[r[rs_sel]] <= r[rd_sel];
      if (reg_we) r[rd_sel] <= wb_sel == 2'b00 ? alu_y : wb_sel == 2'b01 ? imm : rdata;
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat(input int n);
    return n > (2**CW - 1) ? '1 : CW'(n);
  endfunction

  // f = {busy, done, reg_we, mem_re, mem_we, selects_valid}
  function automatic rec_t mk(input logic [6:0] p, input logic [5:0] f, input logic [1:0] wb, input logic [8:0] ir, input int n);
    rec_t e;
    e.pc = p;
    {e.busy, e.done, e.we, e.re, e.mw, e.sel} = f;
    e.wb = wb;
    e.ir = ir;
    e.ret = sat(n);
    return e;
  endfunction

  task automatic model(input int max_i);
    logic [7:0] mr [8];
    logic [7:0] mm [256];
    logic [7:0] a, b, y;
    logic [6:0] p;
    logic [8:0] ir;
    logic z;
    int n;
    for (int i = 0; i < 8; i++) mr[i] = init_r[i];
    for (int i = 0; i < 256; i++) mm[i] = init_m[i];
    p = 7'd0; z = 1'b0; n = 0; halted = 0; ir = 9'd0;
    q.delete();
    while (!halted && n < max_i) begin
      ir = rom[p];
      a = mr[ir[5:3]];
      b = mr[ir[2:0]];
      q.push_back(mk(p, 6'b100000, 2'b00, ir, n));
      q.push_back(mk(p, 6'b100001, 2'b00, ir, n));
      case (ir[8:6])
        3'd0, 3'd1, 3'd2: begin
          y = ir[8:6] == 3'd0 ? a + b : ir[8:6] == 3'd1 ? a - b : a & b;
          z = y == 8'h00;
          mr[ir[5:3]] = y;
          q.push_back(mk(p, 6'b101001, 2'b00, ir, n));
          p = p + 7'd1;
        end
        3'd3: begin
          mr[ir[5:3]] = {5'b0, ir[2:0]};
          q.push_back(mk(p, 6'b101001, 2'b01, ir, n));
          p = p + 7'd1;
        end
        3'd4: begin
          q.push_back(mk(p, 6'b100101, 2'b00, ir, n));
          q.push_back(mk(p, 6'b101001, 2'b10, ir, n));
          mr[ir[5:3]] = mm[b];
          p = p + 7'd1;
        end
        3'd5: begin
          q.push_back(mk(p, 6'b100011, 2'b00, ir, n));
          mm[b] = a;
          p = p + 7'd1;
        end
        3'd6: begin
          q.push_back(mk(p, 6'b100001, 2'b00, ir, n));
          p = z ? {1'b0, ir[5:0]} : p + 7'd1;
        end
        default: begin
          q.push_back(mk(p, 6'b100001, 2'b00, ir, n));
          if (ir[5:0] != 6'd0) p = {1'b0, ir[5:0]};
          else halted = 1;
        end
      endcase
      n++;
    end
    if (halted) q.push_back(mk(p, 6'b010000, 2'b00, ir, n));
    for (int i = 0; i < 8; i++) exp_r[i] = mr[i];
    for (int i = 0; i < 256; i++) exp_m[i] = mm[i];
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = HALT;
    for (int i = 0; i < 8; i++) init_r[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 256; i++) init_m[i] = 8'(i) ^ 8'h5a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; load = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
  endtask

  task automatic compare(input rec_t e);
    check("pc", 32'(pc), 32'(e.pc));
    check("busy", 32'(busy), 32'(e.busy));
    check("done", 32'(done), 32'(e.done));
    check("reg_we", 32'(reg_we), 32'(e.we));
    check("mem_re", 32'(mem_re), 32'(e.re));
    check("mem_we", 32'(mem_we), 32'(e.mw));
    check("retired", 32'(retired), 32'(e.ret));
    if (e.we) check("wb_sel", 32'(wb_sel), 32'(e.wb));
    if (e.sel) begin
      check("rd_sel", 32'(rd_sel), 32'(e.ir[5:3]));
      check("rs_sel", 32'(rs_sel), 32'(e.ir[2:0]));
      check("imm", 32'(imm), {29'd0, e.ir[2:0]});
      if (e.ir[8:6] < 3'd3) check("alu_op", 32'(alu_op), 32'(e.ir[7:6]));
    end
  endtask

  task automatic run(input int max_i, input int poke);
    rec_t e;
    int k, bad;
    do_reset();
    model(max_i);
    k = 0; done_k = -1; re_k = -1; we_k = -1; re_n = 0; mw_n = 0;
    @(negedge clk) start = 1'b1;
    while (q.size() > 0) begin
      @(negedge clk);
      start = k == poke;
      e = q.pop_front();
      compare(e);
      if (done && done_k < 0) done_k = k;
      if (mem_re) begin re_k = k; re_n++; end
      if (reg_we) we_k = k;
      if (mem_we) mw_n++;
      k++;
    end
    start = 1'b0;
    if (halted) begin
      for (int i = 0; i < 8; i++) check($sformatf("reg%0d", i), 32'(r[i]), 32'(exp_r[i]));
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== exp_m[i]) bad++;
      check("mem_words_differing", 32'(bad), 32'd0);
    end
  endtask

  initial begin
    bit found;
    clear_rom();
    do_reset();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_strobes", {29'd0, reg_we, mem_re, mem_we}, 32'd0);
    check("rst_sels", {24'd0, rd_sel, rs_sel, alu_op}, 32'd0);
    check("rst_wb_imm", {22'd0, wb_sel, imm}, 32'd0);
    rom[0] = 9'b011000011; rom[1] = 9'b011001100; rom[2] = 9'b000000001; rom[3] = HALT;
    run(50, -1);
    check("add_r0", 32'(r[0]), 32'h07);
    check("add_retired", 32'(retired), 32'd4);
    check("add_done_cycle", 32'(done_k), 32'd12);
    @(negedge clk);
    check("done_held", 32'(done), 32'd1);
    check("halt_pc", 32'(pc), 32'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_pc", 32'(pc), 32'd0);
    check("restart_retired", 32'(retired), 32'd0);
    run(50, 4);
    check("poke_r0", 32'(r[0]), 32'h07);
    check("poke_done_cycle", 32'(done_k), 32'd12);
    clear_rom();
    init_m[4] = 8'hbb;
    rom[0] = 9'b011000100; rom[1] = 9'b100001000;
    run(50, -1);
    check("ldr_r1", 32'(r[1]), 32'hbb);
    check("ldr_done_cycle", 32'(done_k), 32'd10);
    check("ldr_re_pulses", 32'(re_n), 32'd1);
    check("ldr_re_cycle", 32'(re_k), 32'd5);
    check("ldr_we_cycle", 32'(we_k), 32'd6);
    clear_rom();
    rom[0] = 9'b011000000; rom[1] = 9'b000000000; rom[2] = 9'b110000101;
    rom[3] = 9'b011001001; rom[5] = 9'b011001000;
    run(50, -1);
    check("brz_taken_r1", 32'(r[1]), 32'h00);
    check("brz_taken_pc", 32'(pc), 32'd6);
    check("brz_taken_retired", 32'(retired), 32'd5);
    rom[0] = 9'b011000001;
    run(50, -1);
    check("brz_not_r1", 32'(r[1]), 32'h01);
    check("brz_not_pc", 32'(pc), 32'd4);
    clear_rom();
    rom[0] = 9'b111000011; rom[1] = 9'b011001111; rom[2] = 9'b011001110; rom[3] = 9'b011001000;
    run(50, -1);
    check("jmp_r1", 32'(r[1]), 32'h00);
    check("jmp_retired", 32'(retired), 32'd3);
    check("jmp_done_cycle", 32'(done_k), 32'd9);
    clear_rom();
    rom[0] = 9'b011000100; rom[1] = 9'b011001101; rom[2] = 9'b101001000;
    run(50, -1);
    check("str_mem4", 32'(mem[4]), 32'h05);
    check("str_we_pulses", 32'(mw_n), 32'd1);
    clear_rom();
    init_m[4] = 8'hbb;
    rom[0] = 9'b011000100; rom[1] = 9'b100001000;
    do_reset();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      found = mem_re;
    end
    check("abort_reached_ldr_exec", 32'(found), 32'd1);
    if (found) begin
      reset = 1'b1;
      #1;
      check("abort_strobes_in_reset", {30'd0, mem_re, reg_we}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_pc", 32'(pc), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_reg_we", 32'(reg_we), 32'd0);
      @(posedge clk);
      #1;
      check("abort_reg_we_after", 32'(reg_we), 32'd0);
      check("abort_r1", 32'(r[1]), 32'h11);
    end
    clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 9'b011000001;
    rom[127] = 9'b000001001;
    run(1100, -1);
    @(negedge clk);
    check("wrap_retired_saturated", 32'(retired), 32'h3ff);
    check("wrap_pc", 32'(pc), 32'd76);
    check("wrap_busy", 32'(busy), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control unit for the 9-bit-instruction, 8-bit-data core. Owns the program counter, instruction register and zero flag, and runs the start/done handshake. Fetches from the instruction ROM and sequences the register file, ALU and data memory through fixed FETCH/DECODE/EXEC(/WB) phases until a HALT retires. Sits inside TopLevel between inst_rom and the reg_file/ALU/data_mem datapath.

## Interface
- PC_W, 7: program counter width (128-entry ROM).
- CNT_W, 16: retired-instruction counter width.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin execution at PC 0. Sampled only in IDLE or DONE.
- done  out  1  high in DONE state, held until start or reset.
- busy  out  1  high in FETCH, DECODE, EXEC, WB.
- pc  out  PC_W  instruction ROM address.
- instr  in  9  ROM data, combinational on pc.
- alu_zero  in  1  ALU result == 0.
- rd_sel  out  3  IR[5:3]: destination, or store-data register.
- rs_sel  out  3  IR[2:0]: source, or address register.
- alu_op  out  2  00 add, 01 sub, 10 and.
- reg_we  out  1  register file write strobe.
- wb_sel  out  2  00 ALU, 01 immediate, 10 memory read data.
- imm  out  8  {5'b0, IR[2:0]}.
- mem_re  out  1  data memory read (address = R[rs_sel]).
- mem_we  out  1  data memory write (data R[rd_sel] to address R[rs_sel]).
- retired  out  CNT_W  count of retired instructions, saturating.

## Operation
- Opcode is IR[8:6]:
  - ADD 000, SUB 001, AND 010: rd ← rd op rs; update Z.
  - LDI 011: rd ← imm.
  - LDR 100: rd ← mem[rs].
  - STR 101: mem[rs] ← rd.
  - BRZ 110: if Z then pc ← {0, IR[5:0]}.
  - 111 with IR[5:0]≠0: JMP, pc ← {0, IR[5:0]}.
  - 111 with IR[5:0]=0: HALT.
- States and transitions:
  - IDLE → FETCH on start; pc←0, Z←0, retired←0.
  - FETCH: IR ← instr. Go to DECODE.
  - DECODE: rd_sel, rs_sel and alu_op valid; no strobes. Go to EXEC.
  - EXEC:
    - ALU ops: reg_we=1, wb_sel=00, Z←alu_zero.
    - LDI: reg_we=1, wb_sel=01.
    - STR: mem_we=1.
    - LDR: mem_re=1, then go to WB.
    - BRZ/JMP: load pc. HALT: go to DONE.
    - All others: pc←pc+1 and return to FETCH.
  - WB (LDR only): reg_we=1, wb_sel=10, pc←pc+1. Go to FETCH.
  - DONE: done=1. start → same action as from IDLE.
- pc+1 wraps 127→0.
- Z changes only on ALU ops. LDI/LDR/STR leave Z unchanged.
- retired increments on the last cycle of every instruction, including HALT. It saturates at all-ones.
- Strobes (reg_we, mem_re, mem_we) are decoded from state+IR only. They are 0 in IDLE, FETCH, DECODE and DONE.
- Opcode 000 with all-zero fields is a legal ADD R0,R0 and is not treated as a NOP.

## Timing
- Reset values: state IDLE, pc 0, IR 0, Z 0, retired 0, done 0, busy 0, all strobes 0. rd_sel, rs_sel, alu_op, wb_sel and imm are 0 (derived from IR=0).
- Reset mid-instruction aborts in that cycle. No strobe is asserted during a reset cycle.
- Cycles per instruction:
  - 3 (FETCH, DECODE, EXEC) for ALU, LDI, STR, BRZ, JMP and HALT.
  - 4 for LDR (EXEC, then WB).
- Memory read data is valid in the cycle after mem_re.
- First FETCH is the cycle after start is sampled. done rises the cycle after HALT's EXEC.
- Start pulse: one or more cycles. start while busy is ignored. start held high through DONE restarts immediately.
- start and reset in the same cycle: reset wins.

## Test plan
- LDI R0,3 (011000011); LDI R1,4; ADD R0,R1; HALT → R0=07, Z=0, retired=4, done high exactly 12 cycles after start sampled.
- mem[4]=bb; LDI R0,4; LDR R1,R0; HALT → R1=bb. mem_re is a single pulse in LDR EXEC and reg_we is in the following cycle. done at cycle 10.
- LDI R0,0; ADD R0,R0; BRZ 5; LDI R1,1; HALT; at 5: LDI R1,0; HALT → R1=00. Repeat with LDI R0,1: BRZ not taken, R1=01.
- JMP 3 (111000011) → pc sequence 0,3,4, R1=00. STR R1,R0 with R0=4, R1=5 → mem[4]=05, one mem_we pulse.
- Reset asserted during LDR EXEC → no reg_we follows, state IDLE, pc 0. start pulse during execution → no effect on pc.
- ROM all LDI except pc 127 → pc wraps 127→0. Long run → retired saturates at FFFF.
